// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Latency: MUL_CYCLES/DIV_CYCLES edges after the start edge; HI/LO update on the last one.
// Mul_Busy is raised combinationally on a start and held until the result is written; optional MADD/MSUB via `MUL_MADD_EN.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MulOp,
    input  logic [1:0]  MTHILO,
    input  logic [1:0]  MFHILO,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Mul_Busy,
    output logic [31:0] HiLoOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;

    logic        op_valid, start, done, is_div;
    logic [63:0] result;

    // Opcodes that launch an operation; accumulate ops only exist when compiled in
    always_comb begin
`ifdef MUL_MADD_EN
        op_valid = (MulOp[3] == 1'b0);
`else
        op_valid = (MulOp[3:2] == 2'b00);
`endif
        is_div = (MulOp[3:1] == 3'b001);
        start  = (state == IDLE) && op_valid;
        done   = (state == BUSY) && (cnt == 4'd1);
    end

    assign Mul_Busy = start || (state == BUSY);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: leave IDLE on a start, return when the counter expires
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-shot result datapath evaluated from the latched operands
    logic        sgn;
    logic [63:0] ext_a, ext_b, prod;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, safe_b, q_mag, r_mag, quot, rem;

    always_comb begin
        sgn    = ~op_q[0];
        ext_a  = sgn ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b  = sgn ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod   = ext_a * ext_b;
        // Signed divide via magnitudes: truncation toward zero, remainder follows dividend;
        // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0
        neg_a  = sgn && a_q[31];
        neg_b  = sgn && b_q[31];
        mag_a  = neg_a ? -a_q : a_q;
        mag_b  = neg_b ? -b_q : b_q;
        safe_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_mag  = mag_a / safe_b;
        r_mag  = mag_a % safe_b;
        quot   = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem    = neg_a ? -r_mag : r_mag;
        result = {HI, LO};
        case (op_q)
            4'b0000, 4'b0001: result = prod;
            4'b0010, 4'b0011: result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem, quot};
`ifdef MUL_MADD_EN
            4'b0100, 4'b0101: result = {HI, LO} + prod;
            4'b0110, 4'b0111: result = {HI, LO} - prod;
`endif
            default: result = {HI, LO};
        endcase
    end

    // Operand latch, cycle counter and HI/LO writes (completion or MTHI/MTLO)
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 4'd0;
            op_q <= 4'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            HI   <= 32'd0;
            LO   <= 32'd0;
        end else if (start) begin
            op_q <= MulOp;
            a_q  <= SrcA;
            b_q  <= SrcB;
            cnt  <= is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
        end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
            if (done) begin
                HI <= result[63:32];
                LO <= result[31:0];
            end
        end else begin
            if (MTHILO == 2'b00) HI <= SrcA;
            if (MTHILO == 2'b01) LO <= SrcA;
        end
    end

    // Move-from read port straight off the architectural registers
    always_comb begin
        case (MFHILO)
            2'b01:   HiLoOut = HI;
            2'b10:   HiLoOut = LO;
            default: HiLoOut = 32'd0;
        endcase
    end

endmodule
